// File: rtl/accel_spi_responder.sv
// SPI mode-0 responder emulating an ADXL362-style register map (64 addresses) for the accelerometer reader.
// SCLK/CS/MOSI are oversampled on clk through 2-FF synchronizers plus an edge-detect stage.
module accel_spi_responder #(
  parameter logic [7:0] DEVID_AD  = 8'hAD,
  parameter logic [7:0] DEVID_MST = 8'h1D,
  parameter logic [7:0] PARTID    = 8'hF2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] accel_x,
  input  logic [7:0] accel_y,
  input  logic [7:0] accel_z,
  output logic [7:0] power_ctl,
  output logic       wr_valid,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_RD, S_ADDR_WR, S_DATA_RD, S_DATA_WR, S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_sync_q, sclk_sync_d;
  logic [2:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        cs_armed_q, cs_armed_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [5:0]  addr_q, addr_d;
  logic        miso_q, miso_d;
  logic [7:0]  snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_z_q, snap_z_d;
  logic [7:0]  wreg_q [16];
  logic [7:0]  wreg_d [16];
  logic        wr_valid_q, wr_valid_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        frame_error_q, frame_error_d;

  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0]  rx_byte;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    cs_sync_d   = {cs_sync_q[1:0], CS};
    mosi_sync_d = {mosi_sync_q[0], MOSI};
    sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
    cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
    rx_byte     = {rx_sr_q, mosi_sync_q[1]};
    // In ADDR_RD the address is the byte just completed; in a burst it is the next address.
    rd_addr     = (state_q == S_ADDR_RD) ? rx_byte[5:0] : addr_q + 6'd1;
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr >= 6'h20 && rd_addr <= 6'h2E) begin
      rd_data = wreg_q[rd_addr[3:0]];
    end else begin
      case (rd_addr)
        6'h00:   rd_data = DEVID_AD;
        6'h01:   rd_data = DEVID_MST;
        6'h02:   rd_data = PARTID;
        6'h08:   rd_data = snap_x_q;
        6'h09:   rd_data = snap_y_q;
        6'h0A:   rd_data = snap_z_q;
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    addr_d        = addr_q;
    miso_d        = miso_q;
    snap_x_d      = snap_x_q;
    snap_y_d      = snap_y_q;
    snap_z_d      = snap_z_q;
    wreg_d        = wreg_q;
    wr_valid_d    = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_error_d = 1'b0;
    // A reset taken mid-frame must not see the still-low CS as a fresh frame start.
    cs_armed_d    = cs_armed_q | cs_sync_q[1];
    busy_d        = cs_armed_q & ~cs_sync_q[1];
    if (state_q != S_DATA_RD) miso_d = 1'b0;

    if (cs_rise) begin
      frame_error_d = (bit_cnt_q != 3'd0);
      state_d       = S_IDLE;
      bit_cnt_d     = 3'd0;
      miso_d        = 1'b0;
    end else if (cs_fall && cs_armed_q) begin
      state_d   = S_CMD;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      snap_x_d  = accel_x;
      snap_y_d  = accel_y;
      snap_z_d  = accel_z;
    end else if (state_q != S_IDLE) begin
      if (sclk_rise) begin
        rx_sr_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            S_CMD: begin
              if (rx_byte == 8'h0B)      state_d = S_ADDR_RD;
              else if (rx_byte == 8'h0A) state_d = S_ADDR_WR;
              else                       state_d = S_IGNORE;
            end
            S_ADDR_RD: begin
              addr_d  = rx_byte[5:0];
              tx_sr_d = rd_data;
              state_d = S_DATA_RD;
            end
            S_ADDR_WR: begin
              addr_d  = rx_byte[5:0];
              state_d = S_DATA_WR;
            end
            S_DATA_RD: begin
              addr_d  = addr_q + 6'd1;
              tx_sr_d = rd_data;
            end
            S_DATA_WR: begin
              if (addr_q >= 6'h20 && addr_q <= 6'h2E) begin
                wreg_d[addr_q[3:0]] = rx_byte;
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = rx_byte;
              end else if (addr_q == 6'h1F && rx_byte == 8'h52) begin
                for (int i = 0; i < 16; i++) wreg_d[i] = 8'h00;
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = rx_byte;
              end
              addr_d = addr_q + 6'd1;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_q == S_DATA_RD) begin
        miso_d  = tx_sr_q[7];
        tx_sr_d = {tx_sr_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sclk_sync_q   <= '0;
      cs_sync_q     <= '0;
      mosi_sync_q   <= '0;
      cs_armed_q    <= 1'b0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      addr_q        <= '0;
      miso_q        <= 1'b0;
      snap_x_q      <= '0;
      snap_y_q      <= '0;
      snap_z_q      <= '0;
      for (int i = 0; i < 16; i++) wreg_q[i] <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_armed_q    <= cs_armed_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      addr_q        <= addr_d;
      miso_q        <= miso_d;
      snap_x_q      <= snap_x_d;
      snap_y_q      <= snap_y_d;
      snap_z_q      <= snap_z_d;
      wreg_q        <= wreg_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign MISO        = miso_q;
  assign power_ctl   = wreg_q[13];
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Bench for accel_spi_responder: a bit-banged SPI master with read and write scoreboards.
module tb_accel_spi_responder;
  logic       clk = 1'b0;
  logic       reset, SCLK, CS, MOSI, MISO;
  logic [7:0] accel_x, accel_y, accel_z, power_ctl, wr_data;
  logic       wr_valid, busy, frame_error;
  logic [5:0] wr_addr;

  accel_spi_responder dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .power_ctl(power_ctl),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         wr_seen = 0;
  int         wr_expected = 0;
  int         ferr_seen = 0;
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic [7:0] exp_rd_q [$];
  logic [13:0] exp_wr_q [$];
  logic [13:0] exp_wr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master, 8 clk per SCLK phase; MISO sampled just before each rising edge.
  task automatic spi_frame(input int nbits);
    for (int i = 0; i < 8; i++) rx_buf[i] = 8'h00;
    CS = 1'b0;
    wait_clk(8);
    check_eq("busy_in_frame", busy, 1);
    for (int b = 0; b < nbits; b++) begin
      MOSI = tx_buf[b / 8][7 - (b % 8)];
      wait_clk(8);
      rx_buf[b / 8][7 - (b % 8)] = MISO;
      SCLK = 1'b1;
      wait_clk(8);
      SCLK = 1'b0;
    end
    wait_clk(8);
    CS = 1'b1;
    MOSI = 1'b0;
    wait_clk(10);
    check_eq("busy_after_frame", busy, 0);
  endtask

  task automatic read_burst(input logic [7:0] addr, input int n);
    tx_buf[0] = 8'h0B;
    tx_buf[1] = addr;
    for (int i = 2; i < 8; i++) tx_buf[i] = 8'h00;
    spi_frame((2 + n) * 8);
    for (int i = 0; i < n; i++) check_eq("rd_data", rx_buf[2 + i], exp_rd_q.pop_front());
  endtask

  task automatic write_frame(input logic [7:0] addr, input logic [7:0] data);
    tx_buf[0] = 8'h0A;
    tx_buf[1] = addr;
    tx_buf[2] = data;
    spi_frame(24);
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
    wr_expected++;
  endtask

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_seen++;
      if (exp_wr_q.size() > 0) begin
        exp_wr = exp_wr_q.pop_front();
        check_eq("wr_addr", wr_addr, exp_wr[13:8]);
        check_eq("wr_data", wr_data, exp_wr[7:0]);
        if (wr_addr == 6'h2D) check_eq("power_ctl_with_wr", power_ctl, wr_data);
      end
    end
    if (frame_error) ferr_seen++;
  end

  initial begin
    reset = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    accel_x = 8'h00; accel_y = 8'h00; accel_z = 8'h00;
    wait_clk(5);
    check_eq("rst_miso", MISO, 0);
    check_eq("rst_wr_valid", wr_valid, 0);
    check_eq("rst_frame_error", frame_error, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_power_ctl", power_ctl, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    reset = 1'b0;
    wait_clk(10);
    check_eq("idle_busy", busy, 0);

    // Burst read of the ID constants.
    exp_rd_q.push_back(8'hAD); exp_rd_q.push_back(8'h1D); exp_rd_q.push_back(8'hF2);
    read_burst(8'h00, 3);

    // Snapshot is frozen at CS fall.
    accel_x = 8'h5A; accel_y = 8'h12; accel_z = 8'hC3;
    exp_rd_q.push_back(8'h12);
    fork
      read_burst(8'h09, 1);
      begin wait_clk(40); accel_y = 8'h34; end
    join
    exp_rd_q.push_back(8'h5A); exp_rd_q.push_back(8'h34); exp_rd_q.push_back(8'hC3);
    read_burst(8'h08, 3);

    // Register write and read-back.
    push_wr(6'h2D, 8'h02);
    write_frame(8'h2D, 8'h02);
    check_eq("wr_count_a", wr_seen, wr_expected);
    check_eq("power_ctl_a", power_ctl, 8'h02);
    exp_rd_q.push_back(8'h02);
    read_burst(8'h2D, 1);

    // Address bits [7:6] ignored; read-only target dropped silently.
    write_frame(8'hC0, 8'h55);
    check_eq("wr_count_ro", wr_seen, wr_expected);
    exp_rd_q.push_back(8'hAD);
    read_burst(8'h00, 1);

    // Unknown command.
    tx_buf[0] = 8'h0C; tx_buf[1] = 8'h2D; tx_buf[2] = 8'h07;
    spi_frame(24);
    for (int i = 0; i < 3; i++) check_eq("bad_cmd_miso", rx_buf[i], 8'h00);
    check_eq("wr_count_bad", wr_seen, wr_expected);
    check_eq("power_ctl_bad", power_ctl, 8'h02);

    // Abort after 5 bits of the data byte.
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h2D; tx_buf[2] = 8'hFF;
    spi_frame(21);
    check_eq("frame_error_count", ferr_seen, 1);
    check_eq("wr_count_abort", wr_seen, wr_expected);
    check_eq("power_ctl_abort", power_ctl, 8'h02);

    // Address wrap 0x3F -> 0x00.
    exp_rd_q.push_back(8'h00); exp_rd_q.push_back(8'hAD);
    read_burst(8'h3F, 2);

    // Burst write then burst read-back.
    push_wr(6'h20, 8'h11); push_wr(6'h21, 8'h22);
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h20; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22;
    spi_frame(32);
    check_eq("wr_count_burst", wr_seen, wr_expected);
    exp_rd_q.push_back(8'h11); exp_rd_q.push_back(8'h22);
    read_burst(8'h20, 2);

    // Soft reset clears the writable bank.
    push_wr(6'h1F, 8'h52);
    write_frame(8'h1F, 8'h52);
    check_eq("wr_count_soft", wr_seen, wr_expected);
    check_eq("power_ctl_soft", power_ctl, 8'h00);
    exp_rd_q.push_back(8'h00); exp_rd_q.push_back(8'h00);
    read_burst(8'h20, 2);

    // Reset mid-frame: the remainder of that frame must not write.
    fork
      write_frame(8'h2D, 8'h07);
      begin wait_clk(60); reset = 1'b1; wait_clk(2); reset = 1'b0; end
    join
    check_eq("wr_count_midrst", wr_seen, wr_expected);
    check_eq("power_ctl_midrst", power_ctl, 8'h00);
    check_eq("frame_error_midrst", ferr_seen, 1);
    exp_rd_q.push_back(8'hAD);
    read_burst(8'h00, 1);

    check_eq("rd_queue_empty", exp_rd_q.size(), 0);
    check_eq("wr_queue_empty", exp_wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
